// File: rtl/stack_cmd_frontend.sv
// stack_cmd_frontend
//   Command stage in front of the 2-phase LIFO. Synchronises and debounces the raw push/pop
//   buttons, turns each debounced press into a single two-cycle command aligned to the stack's
//   internal phase, tracks occupancy and raises sticky errors on refused presses.
//
// Ports
//   clk        clock
//   rst_n      asynchronous active-low reset
//   ena        design enable; 0 freezes phase, debounce, FSM and command outputs
//   btn_push   raw push button (asynchronous)
//   btn_pop    raw pop button (asynchronous)
//   data_in    push data, captured on an accepted push press
//   err_clr    synchronous pulse clearing overflow/underflow
//   cmd_push   push command to stack (2 cycles, phase 0 then 1)
//   cmd_pop    pop command to stack (2 cycles, phase 0 then 1)
//   cmd_data   data to stack, stable while cmd_push=1
//   busy       command in flight
//   level      current occupancy 0..DEPTH
//   full       level==DEPTH
//   empty      level==0
//   overflow   sticky: push refused while full
//   underflow  sticky: pop refused while empty
module stack_cmd_frontend #(
   parameter int unsigned DEPTH      = 256,
   parameter int unsigned DEB_CYCLES = 4,
   parameter int unsigned DW         = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         ena,
   input  logic                         btn_push,
   input  logic                         btn_pop,
   input  logic [DW-1:0]                data_in,
   input  logic                         err_clr,
   output logic                         cmd_push,
   output logic                         cmd_pop,
   output logic [DW-1:0]                cmd_data,
   output logic                         busy,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         full,
   output logic                         empty,
   output logic                         overflow,
   output logic                         underflow
);

   localparam int unsigned LW = $clog2(DEPTH + 1);
   localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
   localparam logic [LW-1:0] LVL_MAX  = LW'(DEPTH);

   typedef enum logic [1:0] {StIdle, StArm, StIssue} state_e;

   // Button vectors: bit 0 = push, bit 1 = pop.
   logic [1:0]          sync1_q, sync2_q;
   logic [1:0]          acc_q, acc_d;
   logic [1:0]          prev_q, prev_d;
   logic [1:0][CW-1:0]  cnt_q, cnt_d;
   logic [1:0]          press;

   logic                phase_q;
   state_e              state_q, state_d;
   logic                is_push_q, is_push_d;
   logic                second_q, second_d;
   logic [DW-1:0]       data_q, data_d;
   logic [LW-1:0]       level_q, level_d;
   logic                ovf_q, ovf_d, ovf_set;
   logic                unf_q, unf_d, unf_set;

   // Synchronisers keep sampling even while ena=0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= {btn_pop, btn_push};
         sync2_q <= sync1_q;
      end
   end

   // Accepted level flips after DEB_CYCLES consecutive synced samples that differ from it.
   always_comb begin
      acc_d  = acc_q;
      cnt_d  = cnt_q;
      prev_d = prev_q;
      if (ena) begin
         prev_d = acc_q;
         for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != acc_q[i]) begin
               if (cnt_q[i] == DEB_LAST) begin
                  acc_d[i] = sync2_q[i];
                  cnt_d[i] = '0;
               end else begin
                  cnt_d[i] = cnt_q[i] + 1'b1;
               end
            end else begin
               cnt_d[i] = '0;
            end
         end
      end
   end

   assign press = acc_q & ~prev_q;

   always_comb begin
      state_d   = state_q;
      is_push_d = is_push_q;
      second_d  = second_q;
      data_d    = data_q;
      level_d   = level_q;
      ovf_set   = 1'b0;
      unf_set   = 1'b0;
      if (ena) begin
         unique case (state_q)
            StIdle: begin
               // Push wins a same-cycle tie; the pop press is dropped.
               if (press[0]) begin
                  if (!full) begin
                     data_d    = data_in;
                     is_push_d = 1'b1;
                     state_d   = StArm;
                  end else begin
                     ovf_set = 1'b1;
                  end
               end else if (press[1]) begin
                  if (!empty) begin
                     is_push_d = 1'b0;
                     state_d   = StArm;
                  end else begin
                     unf_set = 1'b1;
                  end
               end
            end
            StArm: begin
               // Leave on phase 1 so the command starts on phase 0.
               if (phase_q) begin
                  state_d  = StIssue;
                  second_d = 1'b0;
               end
            end
            StIssue: begin
               if (!second_q) begin
                  second_d = 1'b1;
               end else begin
                  second_d = 1'b0;
                  state_d  = StIdle;
                  level_d  = is_push_q ? level_q + 1'b1 : level_q - 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // A set in the same cycle as err_clr takes precedence.
   assign ovf_d = ovf_set | (ovf_q & ~err_clr);
   assign unf_d = unf_set | (unf_q & ~err_clr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q     <= '0;
         prev_q    <= '0;
         cnt_q     <= '0;
         phase_q   <= 1'b0;
         state_q   <= StIdle;
         is_push_q <= 1'b0;
         second_q  <= 1'b0;
         data_q    <= '0;
         level_q   <= '0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
      end else begin
         acc_q     <= acc_d;
         prev_q    <= prev_d;
         cnt_q     <= cnt_d;
         if (ena) phase_q <= ~phase_q;
         state_q   <= state_d;
         is_push_q <= is_push_d;
         second_q  <= second_d;
         data_q    <= data_d;
         level_q   <= level_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
      end
   end

   assign busy      = (state_q == StIssue);
   assign cmd_push  = busy & is_push_q;
   assign cmd_pop   = busy & ~is_push_q;
   assign cmd_data  = data_q;
   assign level     = level_q;
   assign full      = (level_q == LVL_MAX);
   assign empty     = (level_q == '0);
   assign overflow  = ovf_q;
   assign underflow = unf_q;

endmodule

// File: tb/tb_stack_cmd_frontend.sv
// tb_stack_cmd_frontend
//   Directed bench for stack_cmd_frontend. A transaction-level model predicts every output each
//   cycle; literal expectations after each scenario pin the model. A second instance with a
//   one-sample debounce is used to land a press inside a command in flight.
module tb_stack_cmd_frontend;

   localparam int DEPTH = 256;
   localparam int DEB   = 4;
   localparam int DW    = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          rst_fast_n = 1'b0;
   logic          ena = 1'b1;
   logic          btn_push = 1'b0;
   logic          btn_pop = 1'b0;
   logic          err_clr = 1'b0;
   logic [DW-1:0] data_in = '0;

   logic          cmd_push, cmd_pop, busy, full, empty, overflow, underflow;
   logic [DW-1:0] cmd_data;
   logic [8:0]    level;

   logic          f_cmd_push, f_cmd_pop, f_busy, f_full, f_empty, f_overflow, f_underflow;
   logic [DW-1:0] f_cmd_data;
   logic [8:0]    f_level;

   stack_cmd_frontend #(.DEPTH(DEPTH), .DEB_CYCLES(DEB), .DW(DW)) u_dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .btn_push(btn_push), .btn_pop(btn_pop),
      .data_in(data_in), .err_clr(err_clr), .cmd_push(cmd_push), .cmd_pop(cmd_pop),
      .cmd_data(cmd_data), .busy(busy), .level(level), .full(full), .empty(empty),
      .overflow(overflow), .underflow(underflow)
   );

   stack_cmd_frontend #(.DEPTH(DEPTH), .DEB_CYCLES(1), .DW(DW)) u_fast (
      .clk(clk), .rst_n(rst_fast_n), .ena(ena), .btn_push(btn_push), .btn_pop(btn_pop),
      .data_in(data_in), .err_clr(err_clr), .cmd_push(f_cmd_push), .cmd_pop(f_cmd_pop),
      .cmd_data(f_cmd_data), .busy(f_busy), .level(f_level), .full(f_full), .empty(f_empty),
      .overflow(f_overflow), .underflow(f_underflow)
   );

   initial forever #5 clk = ~clk;

   // ---------------- model ----------------
   // Cycle index m_cyc counts enabled cycles since reset; its parity is the stack phase.
   // A command accepted in cycle c starts on the first even cycle >= c+2 and lasts 2 cycles.
   logic [1:0]          m_s1, m_s2, m_acc, m_prev;
   logic [1:0][DEB-1:0] m_hist;
   int                  m_cyc, m_start, m_level;
   logic                m_pend, m_is_push, m_ovf, m_unf;
   logic [DW-1:0]       m_data;

   wire [1:0] m_press   = m_acc & ~m_prev;
   wire       m_ovf_set = ena & ~m_pend & m_press[0] & (m_level == DEPTH);
   wire       m_unf_set = ena & ~m_pend & ~m_press[0] & m_press[1] & (m_level == 0);
   wire       m_busy    = m_pend && (m_cyc == m_start || m_cyc == m_start + 1);

   // Level flips once the last DEB samples all equal the opposite value.
   function automatic logic flips(logic [DEB-1:0] h_old, logic s, logic acc);
      logic [DEB-1:0] h;
      h = {h_old[DEB-2:0], s};
      return h == {DEB{~acc}};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_s1 <= '0; m_s2 <= '0; m_acc <= '0; m_prev <= '0; m_hist <= '0;
         m_cyc <= 0; m_start <= 0; m_level <= 0;
         m_pend <= 1'b0; m_is_push <= 1'b0; m_ovf <= 1'b0; m_unf <= 1'b0; m_data <= '0;
      end else begin
         m_s1  <= {btn_pop, btn_push};
         m_s2  <= m_s1;
         m_ovf <= m_ovf_set | (m_ovf & ~err_clr);
         m_unf <= m_unf_set | (m_unf & ~err_clr);
         if (ena) begin
            m_cyc  <= m_cyc + 1;
            m_prev <= m_acc;
            for (int b = 0; b < 2; b++) begin
               m_hist[b] <= {m_hist[b][DEB-2:0], m_s2[b]};
               if (flips(m_hist[b], m_s2[b], m_acc[b])) m_acc[b] <= ~m_acc[b];
            end
            if (!m_pend) begin
               if (m_press[0]) begin
                  if (m_level < DEPTH) begin
                     m_pend    <= 1'b1;
                     m_is_push <= 1'b1;
                     m_data    <= data_in;
                     m_start   <= m_cyc + 2 + ((m_cyc + 2) % 2);
                  end
               end else if (m_press[1]) begin
                  if (m_level > 0) begin
                     m_pend    <= 1'b1;
                     m_is_push <= 1'b0;
                     m_start   <= m_cyc + 2 + ((m_cyc + 2) % 2);
                  end
               end
            end else if (m_cyc == m_start + 1) begin
               m_pend  <= 1'b0;
               m_level <= m_is_push ? m_level + 1 : m_level - 1;
            end
         end
      end
   end

   // ---------------- checking ----------------
   int            n_checks = 0;
   int            n_err = 0;
   int            n_push_cyc, n_pop_cyc, f_push_cyc, f_pop_cyc, f_busy_cyc;
   logic [DW-1:0] last_data, f_last_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clr_counts();
      n_push_cyc = 0; n_pop_cyc = 0; f_push_cyc = 0; f_pop_cyc = 0; f_busy_cyc = 0;
      last_data = '0; f_last_data = '0;
   endtask

   task automatic tick();
      @(negedge clk);
      chk("cmd_push",  32'(cmd_push),  32'(m_busy & m_is_push));
      chk("cmd_pop",   32'(cmd_pop),   32'(m_busy & ~m_is_push));
      chk("busy",      32'(busy),      32'(m_busy));
      chk("level",     32'(level),     32'(m_level));
      chk("full",      32'(full),      32'(m_level == DEPTH));
      chk("empty",     32'(empty),     32'(m_level == 0));
      chk("overflow",  32'(overflow),  32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_unf));
      if (m_busy && m_is_push) chk("cmd_data", 32'(cmd_data), 32'(m_data));
      n_push_cyc += int'(cmd_push);
      n_pop_cyc  += int'(cmd_pop);
      f_push_cyc += int'(f_cmd_push);
      f_pop_cyc  += int'(f_cmd_pop);
      f_busy_cyc += int'(f_busy);
      if (cmd_push) last_data = cmd_data;
      if (f_cmd_push) f_last_data = f_cmd_data;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic press_push(input logic [DW-1:0] d);
      data_in  = d;
      btn_push = 1'b1;
      repeat (10) tick();
      btn_push = 1'b0;
      data_in  = ~d;
      repeat (10) tick();
   endtask

   task automatic press_pop();
      btn_pop = 1'b1;
      repeat (10) tick();
      btn_pop = 1'b0;
      repeat (10) tick();
   endtask

   initial begin
      logic seen;
      clr_counts();

      // Reset state
      do_reset();
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_busy",  32'(busy),  32'd0);
      chk("rst_full",  32'(full),  32'd0);

      // 1) bouncing push, data A5
      clr_counts();
      data_in = 8'hA5;
      for (int i = 0; i < 3; i++) begin
         btn_push = (i % 2 == 0);
         tick();
      end
      btn_push = 1'b1;
      repeat (10) tick();
      btn_push = 1'b0;
      data_in  = 8'h00;
      repeat (10) tick();
      chk("t1_push_cycles", 32'(n_push_cyc), 32'd2);
      chk("t1_cmd_data",    32'(last_data),  32'hA5);
      chk("t1_level",       32'(level),      32'd1);
      chk("t1_empty",       32'(empty),      32'd0);

      // 2) pop on empty, then err_clr
      do_reset();
      clr_counts();
      press_pop();
      chk("t2_pop_cycles", 32'(n_pop_cyc), 32'd0);
      chk("t2_underflow",  32'(underflow), 32'd1);
      chk("t2_level",      32'(level),     32'd0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      tick();
      chk("t2_underflow_clr", 32'(underflow), 32'd0);

      // 3) fill to DEPTH, then one more
      do_reset();
      for (int i = 0; i < DEPTH; i++) press_push(DW'(i));
      chk("t3_full",     32'(full),     32'd1);
      chk("t3_level",    32'(level),    32'd256);
      chk("t3_overflow", 32'(overflow), 32'd0);
      clr_counts();
      press_push(8'h5A);
      chk("t3_no_cmd",    32'(n_push_cyc), 32'd0);
      chk("t3_overflow1", 32'(overflow),   32'd1);
      chk("t3_level_257", 32'(level),      32'd256);

      // 4) simultaneous push and pop at level 3
      do_reset();
      for (int i = 0; i < 3; i++) press_push(DW'(8'h10 + i));
      clr_counts();
      data_in  = 8'h3C;
      btn_push = 1'b1;
      btn_pop  = 1'b1;
      repeat (10) tick();
      btn_push = 1'b0;
      btn_pop  = 1'b0;
      repeat (10) tick();
      chk("t4_push_cycles", 32'(n_push_cyc), 32'd2);
      chk("t4_pop_cycles",  32'(n_pop_cyc),  32'd0);
      chk("t4_level",       32'(level),      32'd4);
      chk("t4_cmd_data",    32'(last_data),  32'h3C);
      chk("t4_errors",      32'({overflow, underflow}), 32'd0);

      // 5) reset during a pop command
      do_reset();
      press_push(8'h77);
      btn_pop = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         tick();
         if (busy) seen = 1'b1;
      end
      chk("t5_busy_seen", 32'(seen), 32'd1);
      chk("t5_cmd_pop",   32'(cmd_pop), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_pop_dropped", 32'(cmd_pop), 32'd0);
      chk("t5_level",       32'(level),   32'd0);
      chk("t5_empty",       32'(empty),   32'd1);
      btn_pop = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (12) tick();

      // 6) second push press while busy (fast instance); glitch is filtered by main instance
      rst_n = 1'b0;
      rst_fast_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      rst_fast_n = 1'b1;
      repeat (3) tick();
      clr_counts();
      data_in = 8'hC3;
      for (int i = 0; i < 12; i++) begin
         btn_push = (i != 2);
         tick();
      end
      btn_push = 1'b0;
      repeat (12) tick();
      chk("t6_push_cycles",   32'(n_push_cyc), 32'd2);
      chk("t6_level",         32'(level),      32'd1);
      chk("t6_f_push_cycles", 32'(f_push_cyc), 32'd2);
      chk("t6_f_busy_cycles", 32'(f_busy_cyc), 32'd2);
      chk("t6_f_pop_cycles",  32'(f_pop_cyc),  32'd0);
      chk("t6_f_level",       32'(f_level),    32'd1);
      chk("t6_f_cmd_data",    32'(f_last_data), 32'hC3);
      chk("t6_f_flags",
          32'({f_full, f_empty, f_overflow, f_underflow}), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
